clock_freq_monitor: RTL

- Single-clock checker and receiving-end counterpart of the simulation clock/reset generator.
- Measures the period of a slower monitored clock (for example a divided eclk-derived toggle or a PLL output) in sclk cycles.
- Declares lock after a run of in-window periods; flags loss of lock.
- Used in the DDR/ECLK bring-up path to gate training until clocks are stable, and in benches as a self-check.

---
 rtl/clock_freq_monitor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/clock_freq_monitor.sv
`timescale 1ns / 1ps
// clock_freq_monitor
//   Measures the period of a slow monitored clock in sclk cycles. Declares lock after
//   LOCK_COUNT consecutive in-window periods. Flags a sticky fault when lock is lost
//   through a bad period or a timeout.
//
// Ports
//   sclk_i          system clock; all logic is on the rising edge
//   reset_i         synchronous active-high reset
//   mon_in_i        monitored clock, asynchronous to sclk_i
//   enable_i        measurement enable; low returns the FSM to idle
//   clear_fault_i   clears the sticky fault (a coincident fault event wins)
//   locked_o        period in window for LOCK_COUNT consecutive periods
//   fault_o         sticky; bad period or timeout while locked
//   period_o        last measured period, in sclk cycles
//   period_valid_o  one-cycle pulse when period_o updates
//   timeout_o       one-cycle pulse when no rising edge arrives within TIMEOUT_COUNT cycles
module clock_freq_monitor #(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned MIN_COUNT     = 90,
  parameter int unsigned MAX_COUNT     = 110,
  parameter int unsigned TIMEOUT_COUNT = 1023,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic                 sclk_i,
  input  logic                 reset_i,
  input  logic                 mon_in_i,
  input  logic                 enable_i,
  input  logic                 clear_fault_i,
  output logic                 locked_o,
  output logic                 fault_o,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 timeout_o
);

  localparam logic [CNT_WIDTH-1:0] MinCnt     = CNT_WIDTH'(MIN_COUNT);
  localparam logic [CNT_WIDTH-1:0] MaxCnt     = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);
  localparam logic [3:0]           LockRun    = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StLocked} state_e;

  state_e                 state_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [3:0]             good_run_q;
  logic                   locked_q, fault_q, period_valid_q, timeout_q;
  logic [CNT_WIDTH-1:0]   period_q;

  logic rise;
  logic good;
  logic [3:0] good_run_inc;

  assign rise         = sync2_q & ~prev_q;
  assign good         = (cnt_q >= MinCnt) && (cnt_q <= MaxCnt);
  assign good_run_inc = good_run_q + 4'd1;

  // Two-flop synchroniser followed by the edge-detect history flop.
  always_ff @(posedge sclk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= mon_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge sclk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      good_run_q     <= '0;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      // Fault-set assignments later in this block override the clear.
      if (clear_fault_i) begin
        fault_q <= 1'b0;
      end

      if (!enable_i) begin
        // Disable wins over any rise or timeout in the same cycle; fault and period hold.
        state_q    <= StIdle;
        locked_q   <= 1'b0;
        good_run_q <= '0;
        cnt_q      <= '0;
      end else begin
        if (state_q != StIdle) begin
          if (rise) begin
            cnt_q <= CntOne;
          end else if (cnt_q != TimeoutCnt) begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        unique case (state_q)
          StIdle: begin
            state_q <= StArm;
            cnt_q   <= '0;
          end

          // First rise only starts the count; there is no previous edge to measure against.
          StArm: begin
            if (rise) begin
              state_q <= StMeasure;
            end
          end

          StMeasure: begin
            if (rise) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (good) begin
                good_run_q <= good_run_inc;
                if (good_run_inc == LockRun) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                end
              end else begin
                good_run_q <= '0;
              end
            end else if (cnt_q == TimeoutCnt) begin
              timeout_q  <= 1'b1;
              good_run_q <= '0;
              locked_q   <= 1'b0;
              state_q    <= StArm;
            end
          end

          StLocked: begin
            if (rise) begin
              period_q       <= cnt_q;
              period_valid_q <= 1'b1;
              if (!good) begin
                locked_q   <= 1'b0;
                fault_q    <= 1'b1;
                good_run_q <= '0;
                state_q    <= StMeasure;
              end
            end else if (cnt_q == TimeoutCnt) begin
              timeout_q  <= 1'b1;
              locked_q   <= 1'b0;
              fault_q    <= 1'b1;
              good_run_q <= '0;
              state_q    <= StArm;
            end
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign locked_o       = locked_q;
  assign fault_o        = fault_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;
  assign timeout_o      = timeout_q;

endmodule
